// File: rtl/inst_rom_rsp.sv
// rtl/inst_rom_rsp.sv - instruction ROM read responder with 4-entry in-order latency queue (optional INST_ROM_DECERR_EN)
module inst_rom_rsp #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [63:0]                  araddr,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [1:0]                   rresp,
  output logic [63:0]                  rdata,
  input  logic                         mem_wen,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [63:0]                  mem_wdata
);

  localparam int         AW  = $clog2(MEM_WORDS);
  localparam logic [2:0] LAT = 3'(LATENCY);

  logic [63:0] mem [MEM_WORDS];

  logic [63:0] q_data [4];
  logic [1:0]  q_resp [4];
  logic [2:0]  q_age  [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;

  logic        accept;
  logic        retire;
  logic [63:0] offset;
  logic [60:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic [63:0] rd_word;
  logic [1:0]  rd_resp;
  logic        unused_bits;

  // Byte offset from the ROM base; the low three bits select a byte within the word and are dropped.
  assign offset   = araddr - ADDR_BASE;
  assign word_idx = offset[63:3];
  assign mem_idx  = word_idx[AW-1:0];
  assign unused_bits = ^{offset[2:0], word_idx[60:AW]};

`ifdef INST_ROM_DECERR_EN
  logic in_range;
  assign in_range = (araddr >= ADDR_BASE) && (word_idx < 61'(MEM_WORDS));

  // Out-of-window fetches still occupy a slot but return a decode error with zero data.
  always_comb begin
    rd_word = 64'h0;
    rd_resp = 2'b11;
    if (in_range) begin
      rd_word = mem[mem_idx];
      rd_resp = 2'b00;
    end
  end
`else
  // Without decode errors the index simply wraps within the ROM.
  always_comb begin
    rd_word = mem[mem_idx];
    rd_resp = 2'b00;
  end
`endif

  assign arready = (count != 3'd4);
  assign accept  = arvalid & arready;
  assign rvalid  = (count != 3'd0) && (q_age[rd_ptr] == LAT);
  assign retire  = rvalid & rready;
  assign rdata   = rvalid ? q_data[rd_ptr] : 64'h0;
  assign rresp   = rvalid ? q_resp[rd_ptr] : 2'b00;

  // Preload port; contents survive reset and a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Capture the fetched word at acceptance so the beat is immune to later preload writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_data[wr_ptr] <= rd_word;
      q_resp[wr_ptr] <= rd_resp;
    end
  end

  // Queue pointers, occupancy and per-entry age counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q_age[i] <= 3'd0;
      end
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (retire) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({accept, retire})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (accept && (wr_ptr == 2'(i))) begin
          q_age[i] <= 3'd0;
        end else if (q_age[i] != LAT) begin
          q_age[i] <= q_age[i] + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_rsp.sv
// tb/tb_inst_rom_rsp.sv - randomized self-checking bench for inst_rom_rsp against a queue-based reference model
module tb_inst_rom_rsp;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int MW  = 1024;
  localparam int LAT = 2;
  localparam int AW  = $clog2(MW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [63:0]   araddr = 64'h0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [1:0]    rresp;
  logic [63:0]   rdata;
  logic          mem_wen = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [63:0]   mem_wdata = 64'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          acc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] mem_m [MW];
  int          cyc = 0;

  always #5 clk = ~clk;

  inst_rom_rsp #(
    .ADDR_BASE(BASE),
    .MEM_WORDS(MW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arvalid(arvalid),
    .arready(arready),
    .araddr(araddr),
    .rvalid(rvalid),
    .rready(rready),
    .rresp(rresp),
    .rdata(rdata),
    .mem_wen(mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );

  // Reference model: a beat is ready once LAT cycles have passed since its acceptance.
  function automatic bit m_valid();
    return (q.size() != 0) && (cyc >= q[0].acc + LAT);
  endfunction

  function automatic logic [63:0] m_data();
    return m_valid() ? q[0].data : 64'h0;
  endfunction

  function automatic logic [1:0] m_resp();
    return m_valid() ? q[0].resp : 2'b00;
  endfunction

  function automatic bit m_ready();
    return q.size() < 4;
  endfunction

  function automatic void m_lookup(input logic [63:0] addr, output logic [63:0] d, output logic [1:0] r);
    longint unsigned off;
    longint unsigned idx;
    off = addr - BASE;
    idx = (off / 8) % MW;
    d = mem_m[idx];
    r = 2'b00;
`ifdef INST_ROM_DECERR_EN
    if (addr < BASE || addr >= BASE + 64'(8 * MW)) begin
      d = 64'h0;
      r = 2'b11;
    end
`endif
  endfunction

  function automatic logic [63:0] rand_in_addr();
    return BASE + 64'(8 * $urandom_range(0, MW - 1)) + 64'($urandom_range(0, 7));
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
  task automatic step(input bit av, input logic [63:0] a, input bit rr,
                      input bit we, input int wa, input logic [63:0] wd);
    bit          acc;
    bit          ret;
    logic [63:0] d;
    logic [1:0]  r;
    arvalid   = av;
    araddr    = a;
    rready    = rr;
    mem_wen   = we;
    mem_waddr = AW'(wa);
    mem_wdata = wd;
    acc = av && m_ready();
    ret = m_valid() && rr;
    d = 64'h0;
    r = 2'b00;
    if (acc) m_lookup(a, d, r);
    @(posedge clk);
    cyc++;
    if (ret) void'(q.pop_front());
    if (acc) q.push_back('{data: d, resp: r, acc: cyc});
    if (we) mem_m[wa] = wd;
    #1;
    arvalid = 1'b0;
    rready  = 1'b0;
    mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b exp=1", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
    rst_n = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < MW; i++) begin
      step(0, 64'h0, 0, 1, i, (i == 5) ? 64'hDEAD_BEEF_0000_0013 : {$urandom, $urandom});
    end
  endtask

  task automatic test_single_read();
    step(1, 64'h8000_002C, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_lat0 rvalid got=%b exp=0", rvalid); end
    step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_lat1 rvalid got=%b exp=0", rvalid); end
    step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_lat2 rvalid got=%b exp=1", rvalid); end
    checks++; if (rdata !== 64'hDEAD_BEEF_0000_0013) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef00000013", rdata); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL single_rresp got=%b exp=00", rresp); end
    step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_retire rvalid got=%b exp=0", rvalid); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      checks++; if (arready !== (k < 4)) begin errors++; $display("FAIL sat_arready k=%0d got=%b exp=%b", k, arready, (k < 4)); end
      step(1, rand_in_addr(), 0, 0, 0, 64'h0);
    end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL sat_full_arready got=%b exp=0", arready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rvalid !== 1'b1 || rdata !== m_data()) begin errors++; $display("FAIL sat_beat i=%0d rvalid=%b rdata=%h exp_rdata=%h", i, rvalid, rdata, m_data()); end
      step(0, 64'h0, 1, 0, 0, 64'h0);
    end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL sat_extra_beat rvalid got=%b exp=0", rvalid); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL sat_drained arready got=%b exp=1", arready); end
  endtask

  task automatic test_full_simul();
    for (int k = 0; k < 4; k++) step(1, rand_in_addr(), 0, 0, 0, 64'h0);
    checks++; if (arready !== 1'b0 || rvalid !== 1'b1) begin errors++; $display("FAIL full_setup arready=%b rvalid=%b exp=0/1", arready, rvalid); end
    step(1, rand_in_addr(), 1, 0, 0, 64'h0);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL full_simul_noaccept arready got=%b exp=1", arready); end
    step(1, rand_in_addr(), 0, 0, 0, 64'h0);
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL full_refill arready got=%b exp=0", arready); end
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      checks++; if (rvalid !== m_valid() || rdata !== m_data()) begin errors++; $display("FAIL full_drain cyc=%0d rvalid=%b rdata=%h exp=%b/%h", cyc, rvalid, rdata, m_valid(), m_data()); end
      step(0, 64'h0, 1, 0, 0, 64'h0);
    end
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL full_end rvalid=%b arready=%b exp=0/1", rvalid, arready); end
  endtask

  task automatic test_backpressure();
    int          p;
    logic [63:0] d0;
    logic [63:0] old;
    p = int'($urandom_range(0, MW - 1));
    old = mem_m[p];
    step(1, BASE + 64'(8 * p), 0, 0, 0, 64'h0);
    for (int i = 0; i < 10 && !m_valid(); i++) step(0, 64'h0, 0, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b1 || rdata !== old) begin errors++; $display("FAIL bp_first rvalid=%b rdata=%h exp=1/%h", rvalid, rdata, old); end
    d0 = rdata;
    for (int i = 0; i < 3; i++) begin
      step(0, 64'h0, 0, 1, p, {$urandom, $urandom});
      checks++; if (rvalid !== 1'b1 || rdata !== d0 || rresp !== 2'b00) begin errors++; $display("FAIL bp_hold i=%0d rvalid=%b rdata=%h rresp=%b exp=1/%h/00", i, rvalid, rdata, rresp, d0); end
    end
    step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_retire rvalid got=%b exp=0", rvalid); end
    old = mem_m[p];
    step(1, BASE + 64'(8 * p), 1, 1, p, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 10 && !m_valid(); i++) step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rdata !== old) begin errors++; $display("FAIL same_cycle_write rdata=%h exp_old=%h", rdata, old); end
    step(1, BASE + 64'(8 * p), 1, 0, 0, 64'h0);
    for (int i = 0; i < 10 && !m_valid(); i++) step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL after_write rdata=%h exp=0123456789abcdef", rdata); end
    step(0, 64'h0, 1, 0, 0, 64'h0);
  endtask

  task automatic test_out_of_range();
    step(1, 64'h7FFF_FFF8, 1, 0, 0, 64'h0);
    for (int i = 0; i < 10 && !m_valid(); i++) step(0, 64'h0, 1, 0, 0, 64'h0);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL oor_rvalid got=%b exp=1", rvalid); end
`ifdef INST_ROM_DECERR_EN
    checks++; if (rresp !== 2'b11 || rdata !== 64'h0) begin errors++; $display("FAIL oor_decerr rresp=%b rdata=%h exp=11/0", rresp, rdata); end
`else
    checks++; if (rresp !== 2'b00 || rdata !== mem_m[MW-1]) begin errors++; $display("FAIL oor_wrap rresp=%b rdata=%h exp=00/%h", rresp, rdata, mem_m[MW-1]); end
`endif
    step(0, 64'h0, 1, 0, 0, 64'h0);
  endtask

  task automatic test_reset_midflight();
    step(1, rand_in_addr(), 0, 0, 0, 64'h0);
    step(1, rand_in_addr(), 0, 0, 0, 64'h0);
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL midrst_assert rvalid=%b arready=%b exp=0/1", rvalid, arready); end
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      step(0, 64'h0, 1, 0, 0, 64'h0);
      checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL midrst_stale i=%0d rvalid=%b arready=%b exp=0/1", i, rvalid, arready); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    for (int i = 0; i < 400; i++) begin
      checks++; if (rvalid !== m_valid()) begin errors++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, m_valid()); end
      checks++; if (arready !== m_ready()) begin errors++; $display("FAIL rand_arready cyc=%0d got=%b exp=%b", cyc, arready, m_ready()); end
      checks++; if (rdata !== m_data()) begin errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, rdata, m_data()); end
      checks++; if (rresp !== m_resp()) begin errors++; $display("FAIL rand_rresp cyc=%0d got=%b exp=%b", cyc, rresp, m_resp()); end
      a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : rand_in_addr();
      step($urandom_range(0, 1) == 1, a, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, MW - 1)), {$urandom, $urandom});
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      checks++; if (rvalid !== m_valid() || rdata !== m_data() || rresp !== m_resp()) begin errors++; $display("FAIL rand_drain cyc=%0d rvalid=%b rdata=%h rresp=%b", cyc, rvalid, rdata, rresp); end
      step(0, 64'h0, 1, 0, 0, 64'h0);
    end
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL rand_end rvalid=%b arready=%b exp=0/1", rvalid, arready); end
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_saturation();
    test_full_simul();
    test_backpressure();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rom_rsp.md
INST_ROM_RSP -- requirements
Module: inst_rom_rsp

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, memory depth in 64-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 2, minimum cycles from AR accept to rvalid, legal range 1..7.
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port arvalid  input  1  read address valid from fetch initiator.
REQ-007 SHALL have port arready  output  1  read address ready.
REQ-008 SHALL have port araddr  input  64  byte read address.
REQ-009 SHALL have port rvalid  output  1  read data valid.
REQ-010 SHALL have port rready  input  1  read data ready.
REQ-011 SHALL have port rresp  output  2  response code, 2'b00 OKAY, 2'b11 DECERR.
REQ-012 SHALL have port rdata  output  64  read data word.
REQ-013 SHALL have port mem_wen  input  1  preload write enable.
REQ-014 SHALL have port mem_waddr  input  log2(MEM_WORDS)  preload word index.
REQ-015 SHALL have port mem_wdata  input  64  preload data.

Function
REQ-016 SHALL hold accepted requests in a 4-entry in-order queue: {rdata, rresp, age[2:0]}, 2-bit read/write pointers, 3-bit count.
REQ-017 SHALL drive arready = (count != 4), independent of arvalid and rready.
REQ-018 SHALL accept on arvalid & arready, ignore araddr[2:0], and index memory with (araddr - ADDR_BASE) >> 3.
REQ-019 SHALL read memory at acceptance and store the word in the entry, so rdata stays stable while rvalid & !rready.
REQ-020 SHALL give the AR read the old word when mem_wen writes the same index in the accepting cycle.
REQ-021 SHALL clear a new entry's age to 0, then increment it each cycle, saturating at LATENCY.
REQ-022 SHALL assert rvalid when the queue is not empty and the head age == LATENCY; a lone request accepted at edge N gives rvalid at edge N+LATENCY.
REQ-023 SHALL present rdata/rresp of the head entry and drive 64'h0/2'b00 when rvalid is low.
REQ-024 SHALL retire the head on rvalid & rready and expose the next entry on the following cycle if its age == LATENCY (back-to-back beats allowed).
REQ-025 SHALL, on simultaneous accept and retire, leave count unchanged and advance both pointers; full stays non-accepting in that cycle (arready already 0).
REQ-026 SHALL wrap pointers modulo 4; count never exceeds 4 or underflows.
REQ-027 SHALL return exactly one R beat per accepted AR, in order, with no flush or drop mechanism.
REQ-028 SHALL not apply rvalid/rready timing to mem_wen writes; writes are applied every cycle mem_wen = 1.

Reset
REQ-029 SHALL, while rst_n = 0, clear count and pointers, hold rvalid = 0, rresp = 2'b00, rdata = 0, arready = 1.
REQ-030 SHALL discard queued requests when reset asserts mid-operation, with no R beat afterwards for them.
REQ-031 SHALL not reset memory contents.

Configuration
REQ-032 SHALL use macro INST_ROM_DECERR_EN; when defined, addresses outside [ADDR_BASE, ADDR_BASE+8*MEM_WORDS) are accepted normally and return rresp = 2'b11, rdata = 64'h0.
REQ-033 SHALL, when INST_ROM_DECERR_EN is undefined, wrap the word index modulo MEM_WORDS and return rresp = 2'b00 for every access.

Verification
REQ-034 SHALL cover single read: preload word 5 = 64'hDEAD_BEEF_0000_0013, AR 0x8000_002C at edge 10, rready = 1 -> rvalid at edge 12, rdata = that word, rresp = 00.
REQ-035 SHALL cover saturation: 5 ARs with rready = 0 -> 4 accepted, arready = 0 after the 4th; rready = 1 -> 4 in-order beats on consecutive cycles, then arready = 1.
REQ-036 SHALL cover full plus simultaneous: queue full, rvalid & rready and arvalid in the same cycle -> no accept in that cycle, accept next cycle, count stays 4 → 3 → 4.
REQ-037 SHALL cover backpressure: rready low 3 cycles during rvalid -> rdata/rresp constant; same-cycle mem_wen to the pending index does not change rdata.
REQ-038 SHALL cover out-of-range: AR 0x7FFF_FFF8 with INST_ROM_DECERR_EN -> rresp = 11, rdata = 0; without it -> rresp = 00, rdata = mem[MEM_WORDS-1].
REQ-039 SHALL cover reset mid-flight: 2 requests queued, rst_n pulsed low -> rvalid = 0, arready = 1, and no stale beat afterwards.
